// File: rtl/escreve_instrucao.sv
// Serial instruction loader: assembles little-endian bytes into 32-bit words and
// writes NUM_INSTR words to instruction memory, holding the CPU in reset until done.
module escreve_instrucao #(
  parameter int NUM_INSTR = 9,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              ocupado,
  output logic              pronto,
  output logic              cpu_rst,
  output logic [1:0]        state_dbg
);

  if (NUM_INSTR > (2 ** ADDR_W)) begin : g_bad_params
    $error("NUM_INSTR does not fit in ADDR_W address bits");
  end

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    RECEBE  = 2'd1,
    ESCREVE = 2'd2,
    FIM     = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_INSTR - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        byte_cnt;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [31:0]       wdata_q;
  logic              xfer;

  // Handshake: a byte moves only on a clock edge where byte_valid and byte_ready
  // are both high; the sender keeps byte_in stable until that edge.
  assign xfer = byte_valid & byte_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OCIOSO;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OCIOSO:  if (start) state_nxt = RECEBE;
      RECEBE:  if (xfer && byte_cnt == 2'd3) state_nxt = ESCREVE;
      ESCREVE: state_nxt = (addr == LAST_ADDR) ? FIM : RECEBE;
      FIM:     if (start) state_nxt = RECEBE;
      default: state_nxt = OCIOSO;
    endcase
  end

  // Write port registers are loaded on the 4th byte so they stay stable
  // after the write while the working address moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      byte_cnt   <= 2'd0;
      word_q     <= 32'd0;
      addr_out_q <= '0;
      wdata_q    <= 32'd0;
    end else begin
      case (state)
        OCIOSO, FIM: begin
          if (start) begin
            addr     <= '0;
            byte_cnt <= 2'd0;
            word_q   <= 32'd0;
          end
        end
        RECEBE: begin
          if (xfer) begin
            word_q[{byte_cnt, 3'b000} +: 8] <= byte_in;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wdata_q    <= {byte_in, word_q[23:0]};
              addr_out_q <= addr;
            end
          end
        end
        ESCREVE: begin
          if (addr != LAST_ADDR) addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    ocupado    = 1'b0;
    pronto     = 1'b0;
    cpu_rst    = 1'b1;
    case (state)
      RECEBE: begin
        byte_ready = 1'b1;
        ocupado    = 1'b1;
      end
      ESCREVE: begin
        mem_we  = 1'b1;
        ocupado = 1'b1;
      end
      FIM: begin
        pronto  = 1'b1;
        cpu_rst = 1'b0;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_out_q;
  assign mem_wdata = wdata_q;
  assign state_dbg = state;

endmodule
